// File: rtl/lab3_cache_mem_arbiter.sv
// ============================================================================
// Module  : lab3_cache_mem_arbiter
// Brief   : Round-robin merge of icache/dcache memory requests onto one port,
//           with in-order response steering via an outstanding-ID FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lab3_cache_mem_arbiter #(
  parameter int p_max_outstanding = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_val,
  output logic        req0_rdy,
  input  logic [76:0] req0_msg,
  input  logic        req1_val,
  output logic        req1_rdy,
  input  logic [76:0] req1_msg,
  output logic        resp0_val,
  input  logic        resp0_rdy,
  output logic [46:0] resp0_msg,
  output logic        resp1_val,
  input  logic        resp1_rdy,
  output logic [46:0] resp1_msg,
  output logic        memreq_val,
  input  logic        memreq_rdy,
  output logic [76:0] memreq_msg,
  input  logic        memresp_val,
  output logic        memresp_rdy,
  input  logic [46:0] memresp_msg,
  output logic        err
);

  localparam int c_ptr_w = $clog2(p_max_outstanding);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic                         prio_q, prio_d;
  logic                         lock_q, lock_d;
  logic                         locked_id_q, locked_id_d;
  logic                         err_q, err_d;
  logic [p_max_outstanding-1:0] ids_q, ids_d;
  logic [c_ptr_w-1:0]           wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0]           rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0]           count_q, count_d;

  logic w_full, w_empty, w_head, w_grant, w_req_fire, w_resp_fire;

  always_comb begin
    w_full  = (count_q == c_cnt_w'(p_max_outstanding));
    w_empty = (count_q == '0);
    w_head  = ids_q[rd_ptr_q];

    if (lock_q)                    w_grant = locked_id_q;
    else if (req0_val && req1_val) w_grant = prio_q;
    else                           w_grant = req1_val;

    memreq_val = reset & ~w_full & (req0_val | req1_val);
    memreq_msg = w_grant ? req1_msg : req0_msg;
    req0_rdy   = memreq_val & memreq_rdy & ~w_grant & req0_val;
    req1_rdy   = memreq_val & memreq_rdy &  w_grant & req1_val;
    w_req_fire = memreq_val & memreq_rdy;

    // With nothing outstanding, stray responses are drained and flagged.
    resp0_val   = reset & ~w_empty & ~w_head & memresp_val;
    resp1_val   = reset & ~w_empty &  w_head & memresp_val;
    memresp_rdy = reset & (w_empty | (w_head ? resp1_rdy : resp0_rdy));
    resp0_msg   = memresp_msg;
    resp1_msg   = memresp_msg;
    w_resp_fire = memresp_val & memresp_rdy & ~w_empty;
  end

  always_comb begin
    prio_d      = prio_q;
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    err_d       = err_q;
    ids_d       = ids_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    if (w_req_fire) begin
      lock_d          = 1'b0;
      prio_d          = ~w_grant;
      ids_d[wr_ptr_q] = w_grant;
      wr_ptr_d        = wr_ptr_q + c_ptr_w'(1);
    end else if (memreq_val) begin
      // Hold the presented request stable until memory accepts it.
      lock_d      = 1'b1;
      locked_id_d = w_grant;
    end

    if (w_resp_fire) rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
    if (w_empty && memresp_val) err_d = 1'b1;

    count_d = count_q + c_cnt_w'(w_req_fire) - c_cnt_w'(w_resp_fire);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prio_q      <= 1'b0;
      lock_q      <= 1'b0;
      locked_id_q <= 1'b0;
      err_q       <= 1'b0;
      ids_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      prio_q      <= prio_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
      err_q       <= err_d;
      ids_q       <= ids_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_lab3_cache_mem_arbiter.sv
// ============================================================================
// Module  : tb_lab3_cache_mem_arbiter
// Brief   : Randomized bench with a transaction-level arbiter/memory model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lab3_cache_mem_arbiter;

  localparam int c_n = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_val, req0_rdy, req1_val, req1_rdy;
  logic [76:0] req0_msg, req1_msg, memreq_msg;
  logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [46:0] resp0_msg, resp1_msg, memresp_msg;
  logic        memreq_val, memreq_rdy, memresp_val, memresp_rdy, err;

  always #5 clk = ~clk;

  lab3_cache_mem_arbiter #(.p_max_outstanding(c_n)) u_dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
    .err(err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [76:0] got, input logic [76:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Transaction-level model: which port is owed the next tie, which port is
  // stuck presenting a stalled request, and the in-order list of issuers.
  bit          m_turn, m_hold, m_hold_port, m_err;
  bit          outst[$];
  logic [46:0] mem_q[$];
  logic [46:0] exp0[$], exp1[$];
  bit          f0, f1;

  function automatic logic [46:0] mem_fn(input logic [76:0] r);
    return r[46:0] ^ {r[76:47], 17'h1a5a5};
  endfunction

  function automatic logic [76:0] rnd77();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[76:0];
  endfunction

  function automatic bit coin(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic model_clear();
    m_turn = 0; m_hold = 0; m_hold_port = 0; m_err = 0;
    outst.delete(); mem_q.delete(); exp0.delete(); exp1.delete();
  endtask

  task automatic step(input int p_req, input int p_mrdy, input int p_mresp,
                      input int p_crdy, input bit spur, input bit do_rst);
    bit full, empty, both, g, ev, h, e_mrr, mfire;
    logic [46:0] e;
    @(posedge clk); #1;
    reset = ~do_rst;
    if (f0) req0_val = 1'b0;
    if (f1) req1_val = 1'b0;
    if (!req0_val && coin(p_req)) begin req0_val = 1'b1; req0_msg = rnd77(); end
    if (!req1_val && coin(p_req)) begin req1_val = 1'b1; req1_msg = rnd77(); end
    memreq_rdy = coin(p_mrdy);
    resp0_rdy  = coin(p_crdy);
    resp1_rdy  = coin(p_crdy);
    memresp_val = 1'b0;
    if (mem_q.size() > 0 && coin(p_mresp)) begin
      memresp_val = 1'b1; memresp_msg = mem_q[0];
    end else if (spur && mem_q.size() == 0) begin
      memresp_val = 1'b1; memresp_msg = 47'(rnd77());
    end
    if (do_rst) begin req0_val = 0; req1_val = 0; memresp_val = 0; end
    @(negedge clk);
    f0 = 0; f1 = 0;
    if (do_rst) begin
      chk("rst_req0_rdy", req0_rdy, 0);
      chk("rst_req1_rdy", req1_rdy, 0);
      chk("rst_memreq_val", memreq_val, 0);
      chk("rst_memresp_rdy", memresp_rdy, 0);
      chk("rst_resp0_val", resp0_val, 0);
      chk("rst_resp1_val", resp1_val, 0);
      model_clear();
      return;
    end
    full  = (outst.size() == c_n);
    empty = (outst.size() == 0);
    both  = req0_val && req1_val;
    g     = m_hold ? m_hold_port : (both ? m_turn : req1_val);
    ev    = !full && (req0_val || req1_val);
    chk("memreq_val", memreq_val, ev);
    if (ev) chk("memreq_msg", memreq_msg, g ? req1_msg : req0_msg);
    chk("req0_rdy", req0_rdy, ev && memreq_rdy && !g && req0_val);
    chk("req1_rdy", req1_rdy, ev && memreq_rdy && g && req1_val);
    h     = empty ? 1'b0 : outst[0];
    e_mrr = empty ? 1'b1 : (h ? resp1_rdy : resp0_rdy);
    chk("resp0_val", resp0_val, !empty && !h && memresp_val);
    chk("resp1_val", resp1_val, !empty && h && memresp_val);
    chk("memresp_rdy", memresp_rdy, e_mrr);
    chk("err", err, m_err);
    if (memresp_val && e_mrr && !empty) begin
      e = h ? exp1.pop_front() : exp0.pop_front();
      chk(h ? "resp1_data" : "resp0_data", h ? resp1_msg : resp0_msg, e);
      void'(outst.pop_front());
      void'(mem_q.pop_front());
    end
    if (empty && memresp_val) m_err = 1;
    mfire = ev && memreq_rdy;
    if (mfire) begin
      e = mem_fn(g ? req1_msg : req0_msg);
      outst.push_back(g);
      mem_q.push_back(e);
      if (g) exp1.push_back(e); else exp0.push_back(e);
      f0 = !g; f1 = g;
      m_turn = !g;
      m_hold = 0;
    end else if (ev) begin
      m_hold = 1;
      m_hold_port = g;
    end
  endtask

  initial begin
    reset = 0; req0_val = 0; req1_val = 0; req0_msg = '0; req1_msg = '0;
    memreq_rdy = 0; resp0_rdy = 0; resp1_rdy = 0; memresp_val = 0; memresp_msg = '0;
    f0 = 0; f1 = 0;
    model_clear();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // Mixed traffic, then heavy backpressure so the ID FIFO fills.
    for (int i = 0; i < 800; i++) step(60, 70, 50, 70, 0, 0);
    for (int i = 0; i < 500; i++) step(80, 80, 5, 60, 0, 0);
    for (int i = 0; i < 300; i++) step(90, 30, 40, 50, 0, 0);
    for (int i = 0; i < 600; i++) step(50, 60, 40, 60, 0, coin(1));
    // Drain, then a stray response with nothing outstanding.
    for (int i = 0; i < 40; i++) step(0, 100, 100, 100, 0, 0);
    chk("drained", outst.size() == 0, 1);
    step(0, 100, 0, 100, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 100, 0, 100, 0, 0);
    chk("err_sticky_model", m_err, 1);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 50; i++) step(60, 70, 50, 70, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
